// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I definitions for the integer pipeline.
//   - opcode constants for the register/immediate ALU formats
//   - funct3 encodings of the integer ALU operations
//   - register-index / word typedefs and the operand bundle carried to the ALU
//   - helper for the I-type immediate
package rv32i_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [6:0] OPC_ALUREG = 7'b0110011;
  localparam logic [6:0] OPC_ALUIMM = 7'b0010011;

  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'b000,
    F3_SLL     = 3'b001,
    F3_SLT     = 3'b010,
    F3_SLTU    = 3'b011,
    F3_XOR     = 3'b100,
    F3_SRL_SRA = 3'b101,
    F3_OR      = 3'b110,
    F3_AND     = 3'b111
  } funct3_e;

  typedef logic [4:0]      reg_idx_t;
  typedef logic [XLEN-1:0] word_t;

  // Everything the ALU sees for one instruction, held in the output register.
  typedef struct packed {
    word_t      rs1;
    word_t      rs2;
    word_t      imm_i;
    word_t      instr;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_alureg;
    reg_idx_t   rd;
    logic       illegal;
  } fetch_bundle_t;

  function automatic word_t imm_i(input word_t instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: bundles the instruction input handshake, the writeback
// port and the operand output handshake of the operand-fetch stage.
//   master : upstream/downstream environment (drives instructions, writebacks,
//            out_ready; observes in_ready and the operand bundle)
//   slave  : the operand_fetch stage itself
interface operand_fetch_if;
  import rv32i_pkg::*;

  logic       in_valid;
  logic       in_ready;
  word_t      in_instr;

  logic       wb_valid;
  reg_idx_t   wb_rd;
  word_t      wb_data;

  logic       out_valid;
  logic       out_ready;
  word_t      out_rs1;
  word_t      out_rs2;
  word_t      out_Iimm;
  word_t      out_instr;
  logic [2:0] out_funct3;
  logic [6:0] out_funct7;
  logic       out_isALUreg;
  reg_idx_t   out_rd;
  logic       out_illegal;

  modport master (
    output in_valid, in_instr,
    output wb_valid, wb_rd, wb_data,
    output out_ready,
    input  in_ready,
    input  out_valid, out_rs1, out_rs2, out_Iimm, out_instr,
    input  out_funct3, out_funct7, out_isALUreg, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_instr,
    input  wb_valid, wb_rd, wb_data,
    input  out_ready,
    output in_ready,
    output out_valid, out_rs1, out_rs2, out_Iimm, out_instr,
    output out_funct3, out_funct7, out_isALUreg, out_rd, out_illegal
  );

endinterface

// File: rtl/rv32i_regfile.sv
// rv32i_regfile: 32 x 32-bit architectural register file.
//   clk, resetn        : clock, synchronous active-low reset (clears all regs)
//   rs1_idx / rs1_data : combinational read port 1
//   rs2_idx / rs2_data : combinational read port 2
//   wr_en, wr_idx,     : synchronous write port; a write in flight this cycle
//   wr_data              is bypassed to both read ports. x0 always reads 0 and
//                        writes to it are dropped.
module rv32i_regfile
  import rv32i_pkg::*;
(
  input  logic     clk,
  input  logic     resetn,
  input  reg_idx_t rs1_idx,
  output word_t    rs1_data,
  input  reg_idx_t rs2_idx,
  output word_t    rs2_data,
  input  logic     wr_en,
  input  reg_idx_t wr_idx,
  input  word_t    wr_data
);

  word_t mem_q [NREGS];
  word_t mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (wr_en && (wr_idx != '0)) begin
      mem_d[wr_idx] = wr_data;
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rs1_data = mem_q[rs1_idx];
    if (rs1_idx == '0) begin
      rs1_data = '0;
    end else if (wr_en && (wr_idx == rs1_idx)) begin
      rs1_data = wr_data;
    end
  end

  always_comb begin
    rs2_data = mem_q[rs2_idx];
    if (rs2_idx == '0) begin
      rs2_data = '0;
    end else if (wr_en && (wr_idx == rs2_idx)) begin
      rs2_data = wr_data;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: RV32I decode / operand-fetch stage feeding the ALU.
//   clk, resetn : clock, synchronous active-low reset
//   bus (slave) : in_valid/in_ready/in_instr instruction handshake,
//                 wb_valid/wb_rd/wb_data writeback port,
//                 out_valid/out_ready plus registered operand bundle
//                 (out_rs1, out_rs2, out_Iimm, out_instr, out_funct3,
//                 out_funct7, out_isALUreg, out_rd, out_illegal)
// Owns the register file and a pending-write scoreboard that holds back
// instructions whose sources are still waiting on a writeback.
module operand_fetch
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  operand_fetch_if.slave  bus
);

  logic [6:0]    opcode;
  logic          dec_alureg;
  logic          dec_aluimm;
  logic          dec_illegal;
  reg_idx_t      rs1_idx;
  reg_idx_t      rs2_idx;
  reg_idx_t      rd_idx;
  word_t         rs1_val;
  word_t         rs2_val;

  logic [31:0]   sb_q, sb_d;
  logic          out_valid_q, out_valid_d;
  fetch_bundle_t bundle_q, bundle_d;

  logic          busy_rs1;
  logic          busy_rs2;
  logic          stall;
  logic          in_ready;
  logic          accept;

  assign opcode      = bus.in_instr[6:0];
  assign dec_alureg  = (opcode == OPC_ALUREG);
  assign dec_aluimm  = (opcode == OPC_ALUIMM);
  assign dec_illegal = !(dec_alureg || dec_aluimm);
  assign rs1_idx     = bus.in_instr[19:15];
  assign rs2_idx     = bus.in_instr[24:20];
  assign rd_idx      = bus.in_instr[11:7];

  rv32i_regfile u_regfile (
    .clk      (clk),
    .resetn   (resetn),
    .rs1_idx  (rs1_idx),
    .rs1_data (rs1_val),
    .rs2_idx  (rs2_idx),
    .rs2_data (rs2_val),
    .wr_en    (bus.wb_valid),
    .wr_idx   (bus.wb_rd),
    .wr_data  (bus.wb_data)
  );

  // A pending register stops being busy in the very cycle its writeback
  // arrives, because the regfile bypass already delivers the new value.
  function automatic logic reg_busy(input reg_idx_t r, input logic [31:0] sb,
                                    input logic wbv, input reg_idx_t wbr);
    if (r == '0) return 1'b0;
    return sb[r] && !(wbv && (wbr == r));
  endfunction

  assign busy_rs1 = reg_busy(rs1_idx, sb_q, bus.wb_valid, bus.wb_rd);
  assign busy_rs2 = reg_busy(rs2_idx, sb_q, bus.wb_valid, bus.wb_rd);

  // The rs2 field is part of the immediate for ALUimm, so it only counts
  // as a source for register-register ops. Illegal opcodes never stall.
  assign stall    = bus.in_valid && !dec_illegal &&
                    (busy_rs1 || (dec_alureg && busy_rs2));
  assign in_ready = resetn && !stall && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    bundle_d    = bundle_q;
    out_valid_d = out_valid_q;
    sb_d        = sb_q;

    if (accept) begin
      bundle_d.rs1       = rs1_val;
      bundle_d.rs2       = rs2_val;
      bundle_d.imm_i     = imm_i(bus.in_instr);
      bundle_d.instr     = bus.in_instr;
      bundle_d.funct3    = bus.in_instr[14:12];
      bundle_d.funct7    = bus.in_instr[31:25];
      bundle_d.is_alureg = dec_alureg;
      bundle_d.rd        = rd_idx;
      bundle_d.illegal   = dec_illegal;
      out_valid_d        = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear first, then set, so a new producer of the register being
    // written back in the same cycle keeps its pending bit.
    if (bus.wb_valid) begin
      sb_d[bus.wb_rd] = 1'b0;
    end
    if (accept && !dec_illegal && (rd_idx != '0)) begin
      sb_d[rd_idx] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bundle_q    <= '0;
      out_valid_q <= 1'b0;
      sb_q        <= '0;
    end else begin
      bundle_q    <= bundle_d;
      out_valid_q <= out_valid_d;
      sb_q        <= sb_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_rs1      = bundle_q.rs1;
  assign bus.out_rs2      = bundle_q.rs2;
  assign bus.out_Iimm     = bundle_q.imm_i;
  assign bus.out_instr    = bundle_q.instr;
  assign bus.out_funct3   = bundle_q.funct3;
  assign bus.out_funct7   = bundle_q.funct7;
  assign bus.out_isALUreg = bundle_q.is_alureg;
  assign bus.out_rd       = bundle_q.rd;
  assign bus.out_illegal  = bundle_q.illegal;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
  import rv32i_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  operand_fetch_if ifc ();

  operand_fetch dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifc)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: architectural registers, pending flags, and the
  // bundle the ALU should currently be looking at.
  logic [31:0] m_regs [32];
  logic        m_pend [32];
  logic        m_valid;
  logic [31:0] m_rs1, m_rs2, m_imm, m_instr;
  logic [2:0]  m_f3;
  logic [6:0]  m_f7;
  logic        m_isreg;
  logic [4:0]  m_rd;
  logic        m_ill;
  logic        exp_ready, obs_ready;

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (ifc.wb_valid && ifc.wb_rd == idx) return ifc.wb_data;
    return m_regs[idx];
  endfunction

  function automatic logic m_busy(input logic [4:0] idx);
    if (idx == 5'd0) return 1'b0;
    if (ifc.wb_valid && ifc.wb_rd == idx) return 1'b0;
    return m_pend[idx];
  endfunction

  function automatic logic [145:0] dut_b();
    return {ifc.out_valid, ifc.out_rs1, ifc.out_rs2, ifc.out_Iimm, ifc.out_instr,
            ifc.out_funct3, ifc.out_funct7, ifc.out_isALUreg, ifc.out_rd, ifc.out_illegal};
  endfunction

  function automatic logic [145:0] mdl_b();
    return {m_valid, m_rs1, m_rs2, m_imm, m_instr, m_f3, m_f7, m_isreg, m_rd, m_ill};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_pend[i] = 1'b0;
    end
    m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_instr = 0;
    m_f3 = 0; m_f7 = 0; m_isreg = 0; m_rd = 0; m_ill = 0;
  endtask

  // One clock: predict in_ready from the model, sample the DUT's, advance
  // the model by the spec rules, then settle just after the rising edge.
  task automatic cycle();
    logic [31:0] ins;
    logic isreg, isimm, ill, stall, acc;
    @(negedge clk);
    ins   = ifc.in_instr;
    isreg = (ins[6:0] == 7'b0110011);
    isimm = (ins[6:0] == 7'b0010011);
    ill   = !(isreg || isimm);
    stall = ifc.in_valid && !ill && (m_busy(ins[19:15]) || (isreg && m_busy(ins[24:20])));
    exp_ready = resetn && !stall && (!m_valid || ifc.out_ready);
    obs_ready = ifc.in_ready;
    acc = ifc.in_valid && exp_ready;
    if (!resetn) begin
      model_clear();
    end else begin
      if (acc) begin
        m_rs1   = m_read(ins[19:15]);
        m_rs2   = m_read(ins[24:20]);
        m_imm   = 32'($signed(ins[31:20]));
        m_instr = ins;
        m_f3    = ins[14:12];
        m_f7    = ins[31:25];
        m_isreg = isreg;
        m_rd    = ins[11:7];
        m_ill   = ill;
        m_valid = 1'b1;
      end else if (ifc.out_ready) begin
        m_valid = 1'b0;
      end
      if (ifc.wb_valid) begin
        if (ifc.wb_rd != 5'd0) m_regs[ifc.wb_rd] = ifc.wb_data;
        m_pend[ifc.wb_rd] = 1'b0;
      end
      if (acc && !ill && ins[11:7] != 5'd0) m_pend[ins[11:7]] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.in_valid = 1'b0;
    ifc.wb_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] data);
    ifc.in_valid = 1'b0;
    ifc.wb_valid = 1'b1;
    ifc.wb_rd    = rd;
    ifc.wb_data  = data;
    cycle();
    ifc.wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    ifc.in_valid = 1'b1; ifc.in_instr = 32'h0000_0033;
    ifc.wb_valid = 1'b1; ifc.wb_rd = 5'd5; ifc.wb_data = 32'h1;
    ifc.out_ready = 1'b1;
    cycle();
    cycle();
    vectors++;
    if (obs_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_in_ready: got %b want 0", obs_ready);
    end
    vectors++;
    if (dut_b() !== '0) begin
      miscompares++; $display("FAIL reset_outputs: got %h want 0", dut_b());
    end
    resetn = 1'b1;
    idle();
    cycle();
  endtask

  task automatic test_addi();
    wb(5'd5, 32'h0000_00AA);
    ifc.in_valid = 1'b1; ifc.in_instr = 32'hFFF2_8313;
    cycle();
    vectors++;
    if (obs_ready !== 1'b1) begin
      miscompares++; $display("FAIL addi_ready: got %b want 1", obs_ready);
    end
    vectors++;
    if ({ifc.out_valid, ifc.out_rs1, ifc.out_Iimm, ifc.out_isALUreg, ifc.out_rd, ifc.out_illegal}
        !== {1'b1, 32'h0000_00AA, 32'hFFFF_FFFF, 1'b0, 5'd6, 1'b0}) begin
      miscompares++;
      $display("FAIL addi_bundle: got v=%b rs1=%h imm=%h isreg=%b rd=%0d ill=%b want 1 aa ffffffff 0 6 0",
               ifc.out_valid, ifc.out_rs1, ifc.out_Iimm, ifc.out_isALUreg, ifc.out_rd, ifc.out_illegal);
    end
    wb(5'd6, 32'h0000_00A9);
  endtask

  task automatic test_raw();
    wb(5'd1, 32'd7);
    wb(5'd2, 32'd9);
    ifc.in_valid = 1'b1; ifc.in_instr = 32'h0020_81B3;
    cycle();
    vectors++;
    if ({obs_ready, ifc.out_rs1, ifc.out_rs2, ifc.out_rd, ifc.out_isALUreg} !== {1'b1, 32'd7, 32'd9, 5'd3, 1'b1}) begin
      miscompares++;
      $display("FAIL raw_add: got rdy=%b rs1=%h rs2=%h rd=%0d isreg=%b want 1 7 9 3 1",
               obs_ready, ifc.out_rs1, ifc.out_rs2, ifc.out_rd, ifc.out_isALUreg);
    end
    ifc.in_instr = 32'h4011_8233;
    for (int i = 0; i < 2; i++) begin
      cycle();
      vectors++;
      if ({obs_ready, ifc.out_valid} !== 2'b00) begin
        miscompares++; $display("FAIL raw_stall: got rdy=%b v=%b want 0 0", obs_ready, ifc.out_valid);
      end
    end
    ifc.wb_valid = 1'b1; ifc.wb_rd = 5'd3; ifc.wb_data = 32'h10;
    cycle();
    vectors++;
    if ({obs_ready, ifc.out_rs1, ifc.out_rs2, ifc.out_funct7, ifc.out_rd} !== {1'b1, 32'h10, 32'd7, 7'h20, 5'd4}) begin
      miscompares++;
      $display("FAIL raw_release: got rdy=%b rs1=%h rs2=%h f7=%h rd=%0d want 1 10 7 20 4",
               obs_ready, ifc.out_rs1, ifc.out_rs2, ifc.out_funct7, ifc.out_rd);
    end
    wb(5'd4, 32'h9);
  endtask

  task automatic test_backpressure();
    ifc.out_ready = 1'b1;
    ifc.in_valid = 1'b1; ifc.in_instr = 32'h1230_0613;
    cycle();
    ifc.out_ready = 1'b0;
    ifc.in_instr = 32'h0550_7693;
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++;
      if ({obs_ready, ifc.out_valid, ifc.out_instr, ifc.out_Iimm} !== {1'b0, 1'b1, 32'h1230_0613, 32'h0000_0123}) begin
        miscompares++;
        $display("FAIL hold: got rdy=%b v=%b instr=%h imm=%h want 0 1 12300613 123",
                 obs_ready, ifc.out_valid, ifc.out_instr, ifc.out_Iimm);
      end
    end
    ifc.out_ready = 1'b1;
    cycle();
    vectors++;
    if ({obs_ready, ifc.out_valid, ifc.out_instr, ifc.out_funct3} !== {1'b1, 1'b1, 32'h0550_7693, 3'd7}) begin
      miscompares++;
      $display("FAIL release: got rdy=%b v=%b instr=%h f3=%0d want 1 1 05507693 7",
               obs_ready, ifc.out_valid, ifc.out_instr, ifc.out_funct3);
    end
    wb(5'd12, 32'h123);
    wb(5'd13, 32'h55);
  endtask

  task automatic test_x0_wb();
    ifc.in_valid = 1'b1; ifc.in_instr = 32'h0000_0733;
    ifc.wb_valid = 1'b1; ifc.wb_rd = 5'd0; ifc.wb_data = 32'hDEAD_BEEF;
    cycle();
    vectors++;
    if ({obs_ready, ifc.out_rs1, ifc.out_rs2} !== {1'b1, 64'd0}) begin
      miscompares++;
      $display("FAIL x0_bypass: got rdy=%b rs1=%h rs2=%h want 1 0 0", obs_ready, ifc.out_rs1, ifc.out_rs2);
    end
    ifc.in_instr = 32'h0007_07B3;
    cycle();
    vectors++;
    if (obs_ready !== 1'b0) begin
      miscompares++; $display("FAIL x0_sb_untouched: got rdy=%b want 0", obs_ready);
    end
    ifc.wb_rd = 5'd14; ifc.wb_data = 32'h77;
    cycle();
    vectors++;
    if ({obs_ready, ifc.out_rs1} !== {1'b1, 32'h77}) begin
      miscompares++; $display("FAIL x0_then_x14: got rdy=%b rs1=%h want 1 77", obs_ready, ifc.out_rs1);
    end
    ifc.in_valid = 1'b0; ifc.wb_valid = 1'b0;
    ifc.in_instr = 32'h0000_0033;
    cycle();
    wb(5'd15, 32'h1);
    vectors++;
    if (m_regs[0] !== 32'd0 || ifc.out_rs1 !== 32'h77) begin
      miscompares++; $display("FAIL x0_model: got x0=%h rs1=%h want 0 77", m_regs[0], ifc.out_rs1);
    end
  endtask

  task automatic test_illegal();
    ifc.in_valid = 1'b1; ifc.in_instr = 32'h0000_04EF;
    cycle();
    vectors++;
    if ({obs_ready, ifc.out_illegal, ifc.out_rd} !== {1'b1, 1'b1, 5'd9}) begin
      miscompares++;
      $display("FAIL jal: got rdy=%b ill=%b rd=%0d want 1 1 9", obs_ready, ifc.out_illegal, ifc.out_rd);
    end
    ifc.in_instr = 32'h0004_8533;
    cycle();
    vectors++;
    if ({obs_ready, ifc.out_illegal} !== 2'b10) begin
      miscompares++; $display("FAIL jal_no_sb: got rdy=%b ill=%b want 1 0", obs_ready, ifc.out_illegal);
    end
    ifc.in_instr = 32'h0005_006F;
    cycle();
    vectors++;
    if ({obs_ready, ifc.out_illegal} !== 2'b11) begin
      miscompares++; $display("FAIL illegal_no_stall: got rdy=%b ill=%b want 1 1", obs_ready, ifc.out_illegal);
    end
    wb(5'd10, 32'h2);
  endtask

  task automatic test_reset_midflight();
    wb(5'd7, 32'h1234);
    ifc.out_ready = 1'b0;
    ifc.in_valid = 1'b1; ifc.in_instr = 32'h0050_0393;
    cycle();
    vectors++;
    if (ifc.out_valid !== 1'b1) begin
      miscompares++; $display("FAIL midflight_load: got v=%b want 1", ifc.out_valid);
    end
    ifc.in_valid = 1'b0;
    resetn = 1'b0;
    ifc.wb_valid = 1'b1; ifc.wb_rd = 5'd7; ifc.wb_data = 32'h55;
    cycle();
    vectors++;
    if ({obs_ready, ifc.out_valid} !== 2'b00) begin
      miscompares++; $display("FAIL midflight_reset: got rdy=%b v=%b want 0 0", obs_ready, ifc.out_valid);
    end
    resetn = 1'b1;
    ifc.wb_valid = 1'b0;
    ifc.out_ready = 1'b1;
    ifc.in_valid = 1'b1; ifc.in_instr = 32'h0073_85B3;
    cycle();
    vectors++;
    if ({obs_ready, ifc.out_rs1, ifc.out_rs2} !== {1'b1, 64'd0}) begin
      miscompares++;
      $display("FAIL midflight_after: got rdy=%b rs1=%h rs2=%h want 1 0 0", obs_ready, ifc.out_rs1, ifc.out_rs2);
    end
    wb(5'd11, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] ins;
    int sel;
    for (int n = 0; n < 600; n++) begin
      resetn = ($urandom_range(0, 59) != 0);
      ins = $urandom;
      sel = $urandom_range(0, 4);
      if (sel < 2)       ins[6:0] = 7'b0110011;
      else if (sel < 4)  ins[6:0] = 7'b0010011;
      if ($urandom_range(0, 1) == 1) begin
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
      end
      ifc.in_valid  = ($urandom_range(0, 3) != 0);
      ifc.in_instr  = ins;
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      ifc.wb_valid  = ($urandom_range(0, 2) == 0);
      ifc.wb_rd     = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      ifc.wb_data   = $urandom;
      cycle();
      vectors++;
      if (obs_ready !== exp_ready) begin
        miscompares++; $display("FAIL rand_ready[%0d]: got %b want %b", n, obs_ready, exp_ready);
      end
      vectors++;
      if (dut_b() !== mdl_b()) begin
        miscompares++; $display("FAIL rand_bundle[%0d]: got %h want %h", n, dut_b(), mdl_b());
      end
    end
    resetn = 1'b1;
    idle();
    cycle();
  endtask

  initial begin
    resetn = 1'b0;
    ifc.in_valid = 1'b0; ifc.in_instr = 32'd0;
    ifc.wb_valid = 1'b0; ifc.wb_rd = 5'd0; ifc.wb_data = 32'd0;
    ifc.out_ready = 1'b1;
    model_clear();
    test_reset();
    test_addi();
    test_raw();
    test_backpressure();
    test_x0_wb();
    test_illegal();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
